// File: rtl/noise_gate.sv
// ---------------------------------------------------------------------------
// noise_gate
//
// Purpose:
//    Dynamics stage placed after the tone filter. It tracks a smoothed
//    amplitude envelope of the trumpet signal and drives a gain ramp through
//    a hysteresis state machine (CLOSED -> ATTACK -> OPEN -> HOLD -> RELEASE).
//    Breath and valve noise between phrases is muted, while played notes pass
//    at unity gain.
//
// Ports:
//    clk         system clock
//    rst_n       synchronous active-low reset, sampled on the rising clk edge
//    enable      1 = gate active, 0 = bypass (gate internals frozen)
//    in_valid    in_sample carries a new sample this cycle
//    in_sample   signed 16-bit sample from the tone filter
//    out_sample  signed 16-bit gated sample
//    out_valid   out_sample updated this cycle
//    gate_state  CLOSED=0, ATTACK=1, OPEN=2, HOLD=3, RELEASE=4
//    gate_open   high in ATTACK, OPEN and HOLD
//
// Configuration:
//    GATE_FLOOR_EN  when defined, the closed gain is FLOOR_GAIN instead of 0,
//                   so some residual room sound passes while the gate is shut.
//
// Gain is unsigned Q1.15 in the range 0..32768, where 32768 is unity.
// ---------------------------------------------------------------------------
module noise_gate #(
   parameter int THRESH_OPEN  = 1024,
   parameter int THRESH_CLOSE = 512,
   parameter int ENV_SHIFT    = 4,
   parameter int HOLD_SAMPLES = 256,
   parameter int ATTACK_STEP  = 4096,
   parameter int RELEASE_STEP = 128,
   parameter int FLOOR_GAIN   = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               in_valid,
   input  logic signed [15:0] in_sample,
   output logic signed [15:0] out_sample,
   output logic               out_valid,
   output logic [2:0]         gate_state,
   output logic               gate_open
);

   typedef enum logic [2:0] {
      CLOSED  = 3'd0,
      ATTACK  = 3'd1,
      OPEN    = 3'd2,
      HOLD    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   // The floor selection is a constant so FLOOR_GAIN stays referenced in
   // both builds; only the macro decides whether it takes effect.
`ifdef GATE_FLOOR_EN
   localparam bit FLOOR_SEL = 1'b1;
`else
   localparam bit FLOOR_SEL = 1'b0;
`endif

   localparam logic [15:0] CLOSED_GAIN  = FLOOR_SEL ? 16'(FLOOR_GAIN) : 16'd0;
   localparam logic [15:0] UNITY_GAIN   = 16'h8000;
   localparam logic [16:0] UNITY_WIDE   = 17'h08000;
   localparam logic [16:0] ATTACK_INC   = 17'(ATTACK_STEP);
   localparam logic [15:0] RELEASE_DEC  = 16'(RELEASE_STEP);
   localparam logic [16:0] RELEASE_LIM  = {1'b0, CLOSED_GAIN} + 17'(RELEASE_STEP);
   localparam logic [16:0] OPEN_LEVEL   = 17'(THRESH_OPEN);
   localparam logic [16:0] CLOSE_LEVEL  = 17'(THRESH_CLOSE);
   localparam logic [15:0] HOLD_RELOAD  = 16'(HOLD_SAMPLES - 1);
   localparam logic signed [15:0] MOST_NEGATIVE = 16'sh8000;

   state_t             state_q;
   state_t             state_n;
   logic [16:0]        env_q;
   logic [16:0]        env_n;
   logic [15:0]        gain_q;
   logic [15:0]        gain_n;
   logic [15:0]        hold_q;
   logic [15:0]        hold_n;

   logic               accept;
   logic signed [16:0] sample_ext;
   logic [16:0]        mag;
   logic signed [16:0] env_diff;
   logic signed [16:0] env_step;
   logic signed [16:0] env_sum;
   logic [16:0]        gain_up;
   logic signed [32:0] sample_wide;
   logic signed [32:0] gain_wide;
   logic signed [15:0] gated;
   logic               open_n;

   assign accept     = enable && in_valid;
   assign gate_state = state_q;

   // Magnitude and envelope tracking. The magnitude is taken in 17 bits so
   // that -32768 can be clamped to 32767, keeping the envelope in 0..32767.
   // The arithmetic shift floors toward minus infinity, which lets a decaying
   // envelope reach 0 and never lets a rising one overshoot the magnitude.
   always_comb begin
      sample_ext = {in_sample[15], in_sample};
      if (in_sample == MOST_NEGATIVE) begin
         mag = 17'd32767;
      end else if (in_sample[15]) begin
         mag = 17'(-sample_ext);
      end else begin
         mag = 17'(sample_ext);
      end
      env_diff = $signed(mag) - $signed(env_q);
      env_step = env_diff >>> ENV_SHIFT;
      env_sum  = $signed(env_q) + env_step;
   end

   // Gain multiply. Both operands are widened to the 33-bit product width;
   // the gain is zero-extended so 32768 stays positive and unity reproduces
   // the input bit-exactly after the Q1.15 shift.
   always_comb begin
      sample_wide = {{17{in_sample[15]}}, in_sample};
      gain_wide   = {17'd0, gain_q};
      gated       = 16'((sample_wide * gain_wide) >>> 15);
   end

   // Next-state logic. Transitions only happen on accepted samples and use
   // the envelope as it was before this sample's update. In HOLD a reopen
   // takes priority over the counter running out, and RELEASE hands its
   // current gain straight back to ATTACK so a reopen has no gain dip.
   always_comb begin
      state_n = state_q;
      env_n   = env_q;
      gain_n  = gain_q;
      hold_n  = hold_q;
      gain_up = {1'b0, gain_q} + ATTACK_INC;
      if (accept) begin
         env_n = 17'(env_sum);
         case (state_q)
            CLOSED: begin
               if (env_q >= OPEN_LEVEL) begin
                  state_n = ATTACK;
               end
            end
            ATTACK: begin
               if (gain_up >= UNITY_WIDE) begin
                  gain_n  = UNITY_GAIN;
                  state_n = OPEN;
               end else begin
                  gain_n = gain_up[15:0];
               end
            end
            OPEN: begin
               if (env_q < CLOSE_LEVEL) begin
                  state_n = HOLD;
                  hold_n  = HOLD_RELOAD;
               end
            end
            HOLD: begin
               if (env_q >= OPEN_LEVEL) begin
                  state_n = OPEN;
               end else if (hold_q == 16'd0) begin
                  state_n = RELEASE;
               end else begin
                  hold_n = hold_q - 16'd1;
               end
            end
            RELEASE: begin
               if (env_q >= OPEN_LEVEL) begin
                  state_n = ATTACK;
               end else if ({1'b0, gain_q} > RELEASE_LIM) begin
                  gain_n = gain_q - RELEASE_DEC;
               end else begin
                  gain_n  = CLOSED_GAIN;
                  state_n = CLOSED;
               end
            end
            default: begin
               state_n = CLOSED;
               gain_n  = CLOSED_GAIN;
            end
         endcase
      end
      open_n = (state_n == ATTACK) || (state_n == OPEN) || (state_n == HOLD);
   end

   // Gate state registers. Reset wins over everything, including a ramp or
   // hold in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= CLOSED;
         env_q     <= 17'd0;
         gain_q    <= CLOSED_GAIN;
         hold_q    <= 16'd0;
         gate_open <= 1'b0;
      end else begin
         state_q   <= state_n;
         env_q     <= env_n;
         gain_q    <= gain_n;
         hold_q    <= hold_n;
         gate_open <= open_n;
      end
   end

   // Output register. In bypass the input is passed through with one cycle
   // of latency, valid or not. While enabled, the output uses the gain from
   // before this edge and out_sample holds between accepted samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_sample <= 16'sd0;
         out_valid  <= 1'b0;
      end else if (!enable) begin
         out_sample <= in_sample;
         out_valid  <= in_valid;
      end else if (in_valid) begin
         out_sample <= gated;
         out_valid  <= 1'b1;
      end else begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_noise_gate.sv
// ---------------------------------------------------------------------------
// tb_noise_gate
//
// Purpose:
//    Self-checking bench for noise_gate with default parameters. A table of
//    directed vectors walks the gate from CLOSED through ATTACK to OPEN and
//    covers edge samples and bypass; hand-written sequences then cover the
//    hold length, reopening from HOLD and RELEASE, the full release to
//    CLOSED, hysteresis while closed, and reset in the middle of a ramp.
//    Defining GATE_FLOOR_EN switches to the expectations of the floor build.
// ---------------------------------------------------------------------------
module tb_noise_gate;

   localparam logic [2:0] S_CLOSED  = 3'd0;
   localparam logic [2:0] S_ATTACK  = 3'd1;
   localparam logic [2:0] S_OPEN    = 3'd2;
   localparam logic [2:0] S_HOLD    = 3'd3;
   localparam logic [2:0] S_RELEASE = 3'd4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               enable;
   logic               in_valid;
   logic signed [15:0] in_sample;
   logic signed [15:0] out_sample;
   logic               out_valid;
   logic [2:0]         gate_state;
   logic               gate_open;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic               en;
      logic               vld;
      logic signed [15:0] smp;
      logic               care;
      logic signed [15:0] exp_out;
      logic               exp_vld;
      logic [2:0]         exp_state;
   } vec_t;

   vec_t vecs[$];

   noise_gate dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_sample  (in_sample),
      .out_sample (out_sample),
      .out_valid  (out_valid),
      .gate_state (gate_state),
      .gate_open  (gate_open)
   );

   always #5 clk = ~clk;

   // Drive one cycle: inputs change on the falling edge, outputs are looked
   // at 1 ns after the following rising edge.
   task automatic applyStimulus(input logic en, input logic vld, input logic signed [15:0] smp);
      @(negedge clk);
      enable    = en;
      in_valid  = vld;
      in_sample = smp;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic care, input logic signed [15:0] exp_out,
                              input logic exp_vld, input logic [2:0] exp_state);
      logic exp_open;
      logic bad;
      exp_open = (exp_state == S_ATTACK) || (exp_state == S_OPEN) || (exp_state == S_HOLD);
      bad = (out_valid !== exp_vld) || (gate_state !== exp_state) || (gate_open !== exp_open);
      if (care && (out_sample !== exp_out)) begin
         bad = 1'b1;
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("[TB] FAIL %s: got out=%0d valid=%0b state=%0d open=%0b, expected out=%0d%s valid=%0b state=%0d open=%0b",
                  name, out_sample, out_valid, gate_state, gate_open, exp_out, care ? "" : "(any)",
                  exp_vld, exp_state, exp_open);
      end
   endtask

   // One reset edge with a valid sample present, to show reset takes priority.
   task automatic doReset(input string name);
      @(negedge clk);
      rst_n     = 1'b0;
      enable    = 1'b1;
      in_valid  = 1'b1;
      in_sample = 16'sd8000;
      @(posedge clk);
      #1;
      checkOutput(name, 1'b1, 16'sd0, 1'b0, S_CLOSED);
      @(negedge clk);
      rst_n    = 1'b1;
      in_valid = 1'b0;
   endtask

   // Feed a constant sample until the gate reaches the target state, checking
   // every output on the way; running out of budget is a failure.
   task automatic driveUntil(input string name, input logic signed [15:0] smp,
                             input logic signed [15:0] exp_out, input logic [2:0] target, input int budget);
      int used;
      used = 0;
      do begin
         applyStimulus(1'b1, 1'b1, smp);
         used++;
         vectors++;
         if ((out_sample !== exp_out) || (out_valid !== 1'b1)) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%0d valid=%0b, expected out=%0d valid=1 (sample %0d)",
                     name, out_sample, out_valid, exp_out, used);
         end
      end while ((gate_state !== target) && (used < budget));
      vectors++;
      if (gate_state !== target) begin
         miscompares++;
         $display("[TB] FAIL %s_timeout: got state=%0d after %0d samples, expected state=%0d",
                  name, gate_state, used, target);
      end
   endtask

   // From OPEN: decay to HOLD with silence, then feed 256 through HOLD and
   // RELEASE. At unity 256 passes as 256, and each RELEASE sample shows
   // gain/128, i.e. one less per step. The last release sample closes.
   task automatic holdThenRelease(input string name, input int rel_samples);
      driveUntil({name, "_decay"}, 16'sd0, 16'sd0, S_HOLD, 400);
      for (int i = 1; i <= 255; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd256);
         checkOutput({name, "_hold"}, 1'b1, 16'sd256, 1'b1, S_HOLD);
      end
      applyStimulus(1'b1, 1'b1, 16'sd256);
      checkOutput({name, "_hold_expire"}, 1'b1, 16'sd256, 1'b1, S_RELEASE);
      for (int j = 1; j < rel_samples; j++) begin
         applyStimulus(1'b1, 1'b1, 16'sd256);
         checkOutput({name, "_release"}, 1'b1, 16'(257 - j), 1'b1, S_RELEASE);
      end
      applyStimulus(1'b1, 1'b1, 16'sd256);
      checkOutput({name, "_release_end"}, 1'b1, 16'(257 - rel_samples), 1'b1, S_CLOSED);
   endtask

   task automatic addVec(input logic en, input logic vld, input logic signed [15:0] smp, input logic care,
                         input logic signed [15:0] exp_out, input logic exp_vld, input logic [2:0] exp_state);
      vec_t v;
      v.en        = en;
      v.vld       = vld;
      v.smp       = smp;
      v.care      = care;
      v.exp_out   = exp_out;
      v.exp_vld   = exp_vld;
      v.exp_state = exp_state;
      vecs.push_back(v);
   endtask

`ifdef GATE_FLOOR_EN

   task automatic runFloorTests();
      int expected[13];
      applyStimulus(1'b1, 1'b1, 16'sd1000);
      checkOutput("floor_closed_1000", 1'b1, 16'sd31, 1'b1, S_CLOSED);
      doReset("floor_reset");
      // Envelope from 0 with 8000: 500, 968, 1407 -> ATTACK on sample 4,
      // ramp 1024 -> 5120 ... 29696 -> saturates to 32768 on sample 12.
      expected = '{250, 250, 250, 250, 250, 1250, 2250, 3250, 4250, 5250, 6250, 7250, 8000};
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd8000);
         checkOutput("floor_open_ramp", 1'b1, 16'(expected[i]), 1'b1,
                     (i < 3) ? S_CLOSED : ((i < 11) ? S_ATTACK : S_OPEN));
      end
      holdThenRelease("floor", 248);
      applyStimulus(1'b1, 1'b1, 16'sd256);
      checkOutput("floor_closed_gain", 1'b1, 16'sd8, 1'b1, S_CLOSED);
   endtask

`else

   task automatic runTable();
      for (int i = 0; i < 3; i++) begin
         addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd0, 1'b1, S_CLOSED);
      end
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd0,    1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd0,    1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd1000, 1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd2000, 1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd3000, 1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd4000, 1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd5000, 1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd6000, 1'b1, S_ATTACK);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd7000, 1'b1, S_OPEN);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd8000, 1'b1, S_OPEN);
      addVec(1'b1, 1'b0, 16'sd123,  1'b0, 16'sd0,    1'b0, S_OPEN);
      addVec(1'b1, 1'b1, -16'sd32768, 1'b1, -16'sd32768, 1'b1, S_OPEN);
      addVec(1'b1, 1'b1, -16'sd100, 1'b1, -16'sd100, 1'b1, S_OPEN);
      addVec(1'b1, 1'b1, 16'sd32767, 1'b1, 16'sd32767, 1'b1, S_OPEN);
      addVec(1'b0, 1'b1, 16'sd555,  1'b1, 16'sd555,  1'b1, S_OPEN);
      addVec(1'b0, 1'b0, -16'sd7,   1'b1, -16'sd7,   1'b0, S_OPEN);
      addVec(1'b0, 1'b1, 16'sd4660, 1'b1, 16'sd4660, 1'b1, S_OPEN);
      addVec(1'b1, 1'b1, 16'sd8000, 1'b1, 16'sd8000, 1'b1, S_OPEN);
      for (int i = 0; i < 4; i++) begin
         addVec(1'b1, 1'b1, -16'sd32768, 1'b1, -16'sd32768, 1'b1, S_OPEN);
      end
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].en, vecs[i].vld, vecs[i].smp);
         checkOutput($sformatf("table[%0d]", i), vecs[i].care, vecs[i].exp_out, vecs[i].exp_vld,
                     vecs[i].exp_state);
      end
   endtask

   // Silence into HOLD, wait 99 HOLD samples, then play again from HOLD
   // sample 100: the gate goes back to OPEN and output stays at unity.
   task automatic holdReopenTest();
      driveUntil("hold_reopen_decay", 16'sd0, 16'sd0, S_HOLD, 400);
      for (int i = 1; i <= 99; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd0);
         checkOutput("hold_reopen_wait", 1'b1, 16'sd0, 1'b1, S_HOLD);
      end
      driveUntil("hold_reopen", 16'sd8000, 16'sd8000, S_OPEN, 8);
   endtask

   // Keep 1000 (envelope settles just under 1024) through HOLD and RELEASE,
   // then play 8000 while the gain passes 16512 -> 16384 so the ramp resumes
   // from 16384: outputs 4000, 4000, 5000, 6000, 7000, then unity.
   task automatic releaseReopenTest();
      int g;
      driveUntil("rel_reopen_decay", 16'sd0, 16'sd0, S_HOLD, 400);
      for (int i = 1; i <= 255; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd1000);
         checkOutput("rel_reopen_hold", 1'b1, 16'sd1000, 1'b1, S_HOLD);
      end
      applyStimulus(1'b1, 1'b1, 16'sd1000);
      checkOutput("rel_reopen_expire", 1'b1, 16'sd1000, 1'b1, S_RELEASE);
      for (int j = 1; j <= 127; j++) begin
         g = 32768 - 128 * (j - 1);
         applyStimulus(1'b1, 1'b1, 16'sd1000);
         checkOutput("rel_reopen_ramp", 1'b1, 16'((1000 * g) / 32768), 1'b1, S_RELEASE);
      end
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_last", 1'b1, 16'sd4031, 1'b1, S_RELEASE);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_attack", 1'b1, 16'sd4000, 1'b1, S_ATTACK);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_16384", 1'b1, 16'sd4000, 1'b1, S_ATTACK);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_20480", 1'b1, 16'sd5000, 1'b1, S_ATTACK);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_24576", 1'b1, 16'sd6000, 1'b1, S_ATTACK);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_28672", 1'b1, 16'sd7000, 1'b1, S_OPEN);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("rel_reopen_unity", 1'b1, 16'sd8000, 1'b1, S_OPEN);
   endtask

   task automatic closedHysteresisTest();
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd1000);
         checkOutput("closed_hysteresis", 1'b1, 16'sd0, 1'b1, S_CLOSED);
      end
   endtask

   task automatic resetMidRampTest();
      doReset("mid_ramp_prereset");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd8000);
      end
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("mid_ramp_attack", 1'b1, 16'sd1000, 1'b1, S_ATTACK);
      doReset("mid_ramp_reset");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 16'sd8000);
         checkOutput("mid_ramp_after_closed", 1'b1, 16'sd0, 1'b1, S_CLOSED);
      end
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("mid_ramp_after_attack", 1'b1, 16'sd0, 1'b1, S_ATTACK);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("mid_ramp_after_gain0", 1'b1, 16'sd0, 1'b1, S_ATTACK);
      applyStimulus(1'b1, 1'b1, 16'sd8000);
      checkOutput("mid_ramp_after_gain1", 1'b1, 16'sd1000, 1'b1, S_ATTACK);
   endtask

`endif

   initial begin
      rst_n     = 1'b0;
      enable    = 1'b1;
      in_valid  = 1'b0;
      in_sample = 16'sd0;
      doReset("reset");
`ifdef GATE_FLOOR_EN
      runFloorTests();
`else
      runTable();
      holdReopenTest();
      releaseReopenTest();
      holdThenRelease("full_release", 256);
      closedHysteresisTest();
      resetMidRampTest();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety net so the bench always ends even if a wait goes wrong.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
